// File: rtl/ap_cmd_arbiter_pkg.sv
// Shared types and constants for the per-rank column-command scheduling blocks.
package mc_pkg;

    localparam int unsigned TOTALBANKS = 16;
    localparam int unsigned BGBK_W     = $clog2(TOTALBANKS);

    typedef logic [BGBK_W-1:0] bgbk_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } arb_state_e;

    localparam logic AP_MODE_RD = 1'b0;
    localparam logic AP_MODE_WR = 1'b1;

endpackage

// File: rtl/ap_cmd_arbiter_if.sv
// Request/command/AP-reservation bundle of the column-command arbiter.
// master is the arbiter side; slave is the request queues, AP counter and PHY side.
interface ap_cmd_arbiter_if;
    import mc_pkg::*;

    logic [TOTALBANKS-1:0] reqValid;
    logic [TOTALBANKS-1:0] reqIsWrite;
    logic [TOTALBANKS-1:0] reqAP;
    logic [TOTALBANKS-1:0] bankBusy;
    logic [TOTALBANKS-1:0] reqPop;
    logic                  cmdValid;
    logic                  cmdReady;
    bgbk_t                 cmdBGBK;
    logic                  cmdIsWrite;
    logic                  cmdAP;
    logic                  apSetup;
    logic                  apMode;
    bgbk_t                 apBGBK;
    logic                  phyAck;
    bgbk_t                 phyAckBGBK;
    logic                  ackTimeoutErr;

    modport master (
        input  reqValid, reqIsWrite, reqAP, bankBusy, cmdReady, phyAck, phyAckBGBK,
        output reqPop, cmdValid, cmdBGBK, cmdIsWrite, cmdAP, apSetup, apMode, apBGBK,
               ackTimeoutErr
    );

    modport slave (
        output reqValid, reqIsWrite, reqAP, bankBusy, cmdReady, phyAck, phyAckBGBK,
        input  reqPop, cmdValid, cmdBGBK, cmdIsWrite, cmdAP, apSetup, apMode, apBGBK,
               ackTimeoutErr
    );

endinterface

// File: rtl/ap_cmd_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of eligible scanning from ptr upward with wrap.
module rr_pick #(
    parameter  int unsigned N = 16,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int unsigned  pos;
    logic [W-1:0] p;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        p     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (32'(ptr) + i) % N;
            p   = W'(pos);
            if (!found && eligible[p]) begin
                found = 1'b1;
                idx   = p;
            end
        end
    end

endmodule

// File: rtl/ap_cmd_arbiter.sv
// Per-rank column-command arbiter: round-robin over banks, skipping AP-busy banks,
// reserving the bank on an AP grant and holding off until the PHY acknowledges it.
module ap_cmd_arbiter
    import mc_pkg::*;
#(
    parameter int unsigned NUMBANK      = 4,
    parameter int unsigned NUMBANKGROUP = 4,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input logic              clk,
    input logic              rst,
    ap_cmd_arbiter_if.master bus
);

    localparam int unsigned TOTAL = NUMBANK * NUMBANKGROUP;
    localparam int unsigned IW    = $clog2(TOTAL);
    localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, rr_ptr_q, pick_idx, ap_bgbk_q;
    logic             is_write_q, ap_q, ap_mode_q, err_q;
    logic             found, accept, timeout, ack_match;
    logic [TW-1:0]    timer_q;
    logic [TOTAL-1:0] eligible, pop;

    assign eligible = bus.reqValid & ~bus.bankBusy;

    rr_pick #(.N(TOTAL)) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .found    (found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        timeout   = 1'b0;
        ack_match = bus.phyAck && (bus.phyAckBGBK == idx_q);
        pop       = '0;
        unique case (state_q)
            IDLE:     if (found) state_d = ISSUE;
            ISSUE: begin
                if (bus.cmdReady) begin
                    accept      = 1'b1;
                    pop[idx_q]  = 1'b1;
                    state_d     = ap_q ? WAIT_ACK : IDLE;
                end
            end
            WAIT_ACK: begin
                // A matching ack in the timeout cycle takes priority over the error.
                if (ack_match) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            is_write_q <= 1'b0;
            ap_q       <= 1'b0;
            ap_bgbk_q  <= '0;
            ap_mode_q  <= AP_MODE_RD;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q <= state_d;
            // AP reservation fields are loaded at grant so they are valid with the apSetup pulse.
            if (state_q == IDLE && found) begin
                idx_q      <= pick_idx;
                is_write_q <= bus.reqIsWrite[pick_idx];
                ap_q       <= bus.reqAP[pick_idx];
                if (bus.reqAP[pick_idx]) begin
                    ap_bgbk_q <= pick_idx;
                    ap_mode_q <= bus.reqIsWrite[pick_idx] ? AP_MODE_WR : AP_MODE_RD;
                end
            end
            if (accept) begin
                rr_ptr_q <= (idx_q == IW'(TOTAL - 1)) ? '0 : idx_q + 1'b1;
                timer_q  <= '0;
            end else if (state_q == WAIT_ACK && timer_q != TW'(ACK_TIMEOUT)) begin
                timer_q <= timer_q + 1'b1;
            end
            if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.cmdValid      = (state_q == ISSUE);
    assign bus.cmdBGBK       = idx_q;
    assign bus.cmdIsWrite    = is_write_q;
    assign bus.cmdAP         = ap_q;
    assign bus.reqPop        = pop;
    assign bus.apSetup       = accept && ap_q;
    assign bus.apMode        = ap_mode_q;
    assign bus.apBGBK        = ap_bgbk_q;
    assign bus.ackTimeoutErr = err_q;

endmodule

// File: tb/tb_ap_cmd_arbiter.sv
// Bench for ap_cmd_arbiter: directed scenarios then randomized traffic against a
// transaction-level model (round-robin pointer, sticky error flag, ack deadline).
module tb_ap_cmd_arbiter;
    import mc_pkg::*;

    localparam int unsigned ACK_TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ap_cmd_arbiter_if bus();

    ap_cmd_arbiter #(.NUMBANK(4), .NUMBANKGROUP(4), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned rr_m   = 0;
    logic        err_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int unsigned rr, input logic [15:0] elig);
        for (int unsigned k = 0; k < 16; k++) begin
            int unsigned b;
            b = (rr + k) % 16;
            if (elig[b]) return int'(b);
        end
        return -1;
    endfunction

    // One arbitration round from IDLE: grant, optional stall, accept.
    task automatic run_cmd(input int unsigned delay, output int granted, output logic was_ap);
        logic [15:0] elig;
        logic [3:0]  ei;
        logic        w, a;
        int          e;
        bus.cmdReady = 1'b0;
        elig    = bus.reqValid & ~bus.bankBusy;
        e       = pick(rr_m, elig);
        granted = e;
        was_ap  = 1'b0;
        if (e < 0) begin
            @(posedge clk); #1;
            chk("idle_valid", 32'(bus.cmdValid), 32'd0);
            chk("idle_pop", 32'(bus.reqPop), 32'd0);
            return;
        end
        ei = 4'(e);
        w  = bus.reqIsWrite[ei];
        a  = bus.reqAP[ei];
        @(posedge clk); #1;
        chk("grant_valid", 32'(bus.cmdValid), 32'd1);
        chk("grant_bgbk", 32'(bus.cmdBGBK), 32'(e));
        chk("grant_wr", 32'(bus.cmdIsWrite), 32'(w));
        chk("grant_ap", 32'(bus.cmdAP), 32'(a));
        for (int unsigned d = 0; d < delay; d++) begin
            bus.reqValid   = bus.reqValid | 16'($urandom);
            bus.reqIsWrite = 16'($urandom);
            bus.reqAP      = 16'($urandom);
            bus.bankBusy   = 16'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.cmdValid), 32'd1);
            chk("stall_bgbk", 32'(bus.cmdBGBK), 32'(e));
            chk("stall_wr", 32'(bus.cmdIsWrite), 32'(w));
            chk("stall_ap", 32'(bus.cmdAP), 32'(a));
            chk("stall_pop", 32'(bus.reqPop), 32'd0);
        end
        bus.cmdReady = 1'b1;
        #1;
        chk("accept_pop", 32'(bus.reqPop), 32'd1 << e);
        chk("accept_setup", 32'(bus.apSetup), 32'(a));
        if (a) begin
            chk("accept_apmode", 32'(bus.apMode), 32'(w));
            chk("accept_apbgbk", 32'(bus.apBGBK), 32'(e));
        end
        @(posedge clk); #1;
        bus.cmdReady     = 1'b0;
        bus.reqValid[ei] = 1'b0;
        rr_m = (int'(e) + 1) % 16;
        chk("post_valid", 32'(bus.cmdValid), 32'd0);
        chk("post_pop", 32'(bus.reqPop), 32'd0);
        chk("post_setup", 32'(bus.apSetup), 32'd0);
        chk("post_err", 32'(bus.ackTimeoutErr), 32'(err_m));
        if (a) bus.bankBusy[ei] = 1'b1;
        was_ap = a;
    endtask

    // Wait for the AP acknowledge; ack_at < 0 means the PHY never answers.
    task automatic wait_ack(input int e, input int ack_at, input int wrong_at, input int wrong_bank);
        for (int j = 0; j < int'(ACK_TO); j++) begin
            logic done;
            bus.phyAck = 1'b0;
            if (j == wrong_at) begin
                bus.phyAck     = 1'b1;
                bus.phyAckBGBK = 4'(wrong_bank);
            end
            if (j == ack_at) begin
                bus.phyAck     = 1'b1;
                bus.phyAckBGBK = 4'(e);
            end
            done = (j == ack_at) || (j == int'(ACK_TO) - 1);
            if (j != ack_at && j == int'(ACK_TO) - 1) err_m = 1'b1;
            chk("wait_valid", 32'(bus.cmdValid), 32'd0);
            chk("wait_pop", 32'(bus.reqPop), 32'd0);
            @(posedge clk); #1;
            bus.phyAck = 1'b0;
            chk("wait_err", 32'(bus.ackTimeoutErr), 32'(err_m));
            if (done) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g;
        logic a;
        bus.reqValid   = '0;
        bus.reqIsWrite = '0;
        bus.reqAP      = '0;
        bus.bankBusy   = '0;
        bus.cmdReady   = 1'b0;
        bus.phyAck     = 1'b0;
        bus.phyAckBGBK = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.cmdValid), 32'd0);
        chk("rst_bgbk", 32'(bus.cmdBGBK), 32'd0);
        chk("rst_wr", 32'(bus.cmdIsWrite), 32'd0);
        chk("rst_ap", 32'(bus.cmdAP), 32'd0);
        chk("rst_pop", 32'(bus.reqPop), 32'd0);
        chk("rst_setup", 32'(bus.apSetup), 32'd0);
        chk("rst_apmode", 32'(bus.apMode), 32'd0);
        chk("rst_apbgbk", 32'(bus.apBGBK), 32'd0);
        chk("rst_err", 32'(bus.ackTimeoutErr), 32'd0);
        rst = 1'b1;

        bus.reqValid = 16'h0001;
        run_cmd(0, g, a);

        bus.reqValid = 16'h8001;
        run_cmd(0, g, a);
        run_cmd(0, g, a);

        bus.reqValid   = 16'h0020;
        bus.reqAP      = 16'h0020;
        bus.reqIsWrite = 16'h0020;
        run_cmd(0, g, a);
        bus.reqValid[9] = 1'b1;
        wait_ack(g, 5, 2, 3);
        bus.reqAP      = '0;
        bus.reqIsWrite = '0;
        run_cmd(0, g, a);

        bus.bankBusy = 16'h0004;
        bus.reqValid = 16'h0006;
        run_cmd(0, g, a);
        repeat (3) run_cmd(0, g, a);
        bus.bankBusy = '0;
        run_cmd(0, g, a);

        bus.reqValid   = 16'h0100;
        bus.reqIsWrite = 16'h0100;
        run_cmd(10, g, a);
        bus.reqValid   = '0;
        bus.reqAP      = '0;
        bus.reqIsWrite = '0;
        bus.bankBusy   = '0;

        bus.reqValid = 16'h0400;
        bus.reqAP    = 16'h0400;
        run_cmd(0, g, a);
        wait_ack(g, int'(ACK_TO) - 1, -1, 0);

        bus.bankBusy = '0;
        bus.reqValid = 16'h0800;
        bus.reqAP    = 16'h0800;
        run_cmd(0, g, a);
        wait_ack(g, -1, -1, 0);
        bus.reqAP    = '0;
        bus.reqValid = 16'h1000;
        run_cmd(0, g, a);

        bus.bankBusy = '0;
        bus.reqValid = 16'h0008;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(bus.cmdValid), 32'd1);
        chk("pre_rst_bgbk", 32'(bus.cmdBGBK), 32'(pick(rr_m, 16'h0008)));
        bus.cmdReady = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.cmdValid), 32'd0);
        chk("arst_err", 32'(bus.ackTimeoutErr), 32'd0);
        chk("arst_pop", 32'(bus.reqPop), 32'd0);
        chk("arst_setup", 32'(bus.apSetup), 32'd0);
        @(posedge clk); #1;
        chk("arst_pop_hold", 32'(bus.reqPop), 32'd0);
        bus.cmdReady = 1'b0;
        rst   = 1'b1;
        rr_m  = 0;
        err_m = 1'b0;
        run_cmd(0, g, a);

        bus.reqValid = '0;
        bus.bankBusy = '0;
        for (int it = 0; it < 60; it++) begin
            bus.reqValid   = bus.reqValid | 16'($urandom & $urandom);
            bus.reqIsWrite = 16'($urandom);
            bus.reqAP      = 16'($urandom & $urandom);
            for (int b = 0; b < 16; b++)
                if ($urandom_range(3) == 0) bus.bankBusy[b] = 1'b0;
            run_cmd($urandom_range(3), g, a);
            if (a) begin
                int ack_at;
                ack_at = int'($urandom_range(70));
                if (ack_at > int'(ACK_TO) - 1) ack_at = -1;
                wait_ack(g, ack_at, int'($urandom_range(10)), (g + 1 + int'($urandom_range(14))) % 16);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_cmd_arbiter.md
Name: ap_cmd_arbiter

Overview:
Per-rank column-command arbiter. It shares one PHY command slot between TOTALBANKS per-bank request queues using round-robin, and skips banks whose auto-precharge (AP) is still in progress, as reported by the per-bank AP timing counter. When it grants an AP command, it reserves the bank in the AP timing counter (apSetup/apMode/apBGBK) and waits for the PHY AP acknowledge before it arbitrates again.

Parameters:
NUMBANK, 4, banks per bank group
NUMBANKGROUP, 4, bank groups per rank
TOTALBANKS, NUMBANK*NUMBANKGROUP, flat bank count; index = {BG,BK}
ACK_TIMEOUT, 64, cycles allowed in WAIT_ACK before error

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
reqValid  in  TOTALBANKS  per-bank request pending; held until reqPop
reqIsWrite  in  TOTALBANKS  1=write, 0=read
reqAP  in  TOTALBANKS  1=command carries auto-precharge
bankBusy  in  TOTALBANKS  1=AP pending/in progress (from AP timing counter)
cmdValid  out  1  command presented to PHY
cmdReady  in  1  PHY accepts command this cycle
cmdBGBK  out  $clog2(TOTALBANKS)  granted bank index
cmdIsWrite  out  1  granted direction
cmdAP  out  1  granted AP flag
reqPop  out  TOTALBANKS  one-hot, 1-cycle pulse on accept
apSetup  out  1  1-cycle pulse: reserve AP for apBGBK
apMode  out  1  0=read AP (tRP), 1=write AP (tWR+tRP)
apBGBK  out  $clog2(TOTALBANKS)  bank being reserved
phyAck  in  1  PHY AP acknowledge
phyAckBGBK  in  $clog2(TOTALBANKS)  bank of phyAck
ackTimeoutErr  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async): state=IDLE, rrPtr=0, timer=0. Registered outputs are all 0: cmdValid, cmdBGBK, cmdIsWrite, cmdAP, apBGBK, apMode, ackTimeoutErr. Pulse outputs reqPop and apSetup are 0. Reset mid-operation abandons any grant; no pop or setup is produced.
- eligible = reqValid & ~bankBusy (combinational).
- IDLE: if eligible!=0, pick the first set index scanning rrPtr, rrPtr+1, ... with wrap mod TOTALBANKS. Latch idx, reqIsWrite[idx] and reqAP[idx] into the cmd registers. Next state is ISSUE. Grant cycle N gives cmdValid=1 at N+1.
- ISSUE: cmdValid=1 and all cmd fields stable until accepted. bankBusy/reqValid are not re-sampled. On cmdValid&&cmdReady (same cycle, combinational pulses):
  - reqPop[idx]=1 for one cycle.
  - rrPtr <= (idx+1) mod TOTALBANKS; wrap from 15 to 0.
  - if cmdAP: apSetup=1, apMode=cmdIsWrite, apBGBK=idx. Next state WAIT_ACK, timer <= 0.
  - else: next state IDLE.
  - cmdValid drops the next cycle.
- WAIT_ACK: cmdValid=0, no arbitration. timer increments each cycle.
  - phyAck && phyAckBGBK==idx: go to IDLE.
  - phyAck with a non-matching bank: ignored.
  - timer==ACK_TIMEOUT-1 without a match: ackTimeoutErr <= 1 (sticky until reset), go to IDLE.
  - Matching ack in the same cycle as timeout: the ack wins; no error.
- The arbiter does not clear bankBusy. The AP counter sets it the cycle after apSetup, so a bank just reserved is excluded from the next IDLE scan.
- All requests busy or none valid: stay in IDLE, outputs 0, rrPtr unchanged.
- Timer width is $clog2(ACK_TIMEOUT+1) and it saturates; index arithmetic is modulo TOTALBANKS.

Decomposition:
- Shared package (mc_pkg): TOTALBANKS-derived BGBK_W localparam, typedef bgbk_t, state enum arb_state_e {IDLE, ISSUE, WAIT_ACK}, apMode encoding constants AP_MODE_RD=0 and AP_MODE_WR=1.
- One sub-module, rr_pick: combinational rotate-priority encoder. Inputs: eligible vector, rrPtr. Outputs: found, idx. Reusable by other per-rank schedulers.

Test Plan:
1. reqValid=0x0001, reqAP[0]=0, cmdReady=1 from start → cmdValid 1 cycle after grant with cmdBGBK=0; reqPop=0x0001 for one cycle; apSetup stays 0; back to IDLE; rrPtr=1.
2. reqValid=0x8001 held, rrPtr=1, no AP → bank 15 granted first, then bank 0 (wrap). The pop sequence 0x8000 then 0x0001 checks wrap-around.
3. reqValid[5]=1, reqAP[5]=1, reqIsWrite[5]=1, cmdReady=1 → apSetup pulse with apMode=1, apBGBK=5, coincident with reqPop[5]. No new cmdValid until phyAck with phyAckBGBK=5. A phyAck with phyAckBGBK=3 sent earlier is ignored.
4. bankBusy=0x0004 with reqValid=0x0006 → bank 1 granted; bank 2 is never granted while busy. After bankBusy clears, bank 2 is granted on the next IDLE scan.
5. AP grant followed by no phyAck for 64 cycles → ackTimeoutErr=1 at cycle 64 and stays 1; arbitration resumes. Then assert rst=0 while in ISSUE → cmdValid=0 and ackTimeoutErr=0 immediately (async), and no reqPop is produced.
6. cmdReady held 0 for 10 cycles in ISSUE while reqValid changes → cmdBGBK/cmdIsWrite/cmdAP stay stable and cmdValid stays 1; pop occurs only in the cycle cmdReady=1.
